// File: rtl/hack_fetch.sv
// hack_fetch: Hack CPU fetch stage; drives a 1-cycle ROM and hands words to decode over valid/ready.
// The ROM address is the combinational next-PC, so stalls re-read and jumps redirect without bubbles.
module hack_fetch #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [15:0]       jump_target,
  output logic              range_err,
  output logic [15:0]       instr_count
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  logic [15:0]       r_count;
  logic              r_range_err;
  logic              w_fire;
  logic              w_oob;
  logic [ADDR_W-1:0] w_next_pc;
  always_comb begin
    w_fire      = r_pend & run & instr_ready;
    w_oob       = jump & ((jump_target >> ADDR_W) != 16'd0);
    w_next_pc   = jump ? jump_target[ADDR_W-1:0] : w_fire ? r_pc + 1'b1 : r_pc;
    rom_address = reset_n ? w_next_pc : '0;
    instr       = rom_data;
    instr_pc    = r_pc;
    instr_valid = r_pend & run;
    range_err   = r_range_err;
    instr_count = r_count;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= '0;
      r_pend      <= 1'b0;
      r_count     <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_pend      <= 1'b1;
      r_count     <= (w_fire && r_count != 16'hFFFF) ? r_count + 16'd1 : r_count;
      r_range_err <= r_range_err | w_oob;
    end
  end
endmodule

// File: tb/tb_hack_fetch.sv
// tb_hack_fetch: directed stimulus with a queue scoreboard of expected {pc, word} per accepted instruction.
module tb_hack_fetch;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_target = 16'd0;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [15:0] instr_count;
  logic [3:0]  rom_address;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        range_err;
  logic [15:0] mem [16];
  logic [19:0] q [$];
  logic [19:0] exp_w;
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b1;

  always #5 clock = ~clock;

  hack_fetch #(.ADDR_W(4), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .rom_address(rom_address),
    .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump(jump), .jump_target(jump_target),
    .range_err(range_err), .instr_count(instr_count)
  );

  always @(posedge clock) rom_data <= mem[rom_address];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] p);
    q.push_back({p, mem[p]});
  endtask

  always @(negedge clock) begin
    if (mon_en && reset_n && instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fire: got pc %0h instr %0h expected none", instr_pc, instr);
      end else begin
        exp_w = q.pop_front();
        chk("fetch_pc_instr", {12'd0, instr_pc, instr}, {12'd0, exp_w});
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'hEA90; mem[1] = 16'hE320; mem[2] = 16'hEE88;
    mem[3] = 16'hE7D0; mem[4] = 16'h0001; mem[5] = 16'hEA87;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", instr_valid, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_range_err", range_err, 0);
    cyc();
    reset_n = 1'b1; run = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    chk("first_cycle_invalid", instr_valid, 0);
    push(0); push(1); push(2);
    cyc(); cyc(); cyc();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_instr", instr, 16'hEE88);
      chk("stall_pc", instr_pc, 2);
      chk("stall_rom_address", rom_address, 2);
      chk("stall_count", instr_count, 2);
      cyc();
    end
    instr_ready = 1'b1;
    push(3); push(4); push(5);
    cyc(); cyc(); cyc();
    jump = 1'b1; jump_target = 16'h0001;
    push(1);
    @(negedge clock);
    chk("jump_rom_address", rom_address, 1);
    cyc();
    jump_target = 16'h0013;
    @(negedge clock);
    chk("jump_count", instr_count, 6);
    chk("oob_rom_address", rom_address, 3);
    cyc();
    jump_target = 16'h000E; instr_ready = 1'b0;
    push(14); push(15); push(0);
    @(negedge clock);
    chk("range_err_set", range_err, 1);
    chk("oob_pc", instr_pc, 3);
    chk("oob_count", instr_count, 7);
    chk("discard_rom_address", rom_address, 14);
    cyc();
    jump = 1'b0; instr_ready = 1'b1;
    cyc(); cyc(); cyc();
    run = 1'b0;
    @(negedge clock);
    chk("run0_valid", instr_valid, 0);
    chk("run0_rom_address", rom_address, 1);
    chk("wrap_count", instr_count, 10);
    cyc();
    jump = 1'b1; jump_target = 16'h0004;
    @(negedge clock);
    chk("run0_jump_valid", instr_valid, 0);
    chk("run0_jump_rom_address", rom_address, 4);
    cyc();
    jump = 1'b0; run = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    chk("run1_valid", instr_valid, 1);
    chk("run1_instr", instr, 16'h0001);
    chk("run1_pc", instr_pc, 4);
    chk("run1_count", instr_count, 10);
    chk("range_err_sticky", range_err, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_pc", instr_pc, 0);
    chk("async_count", instr_count, 0);
    chk("async_range_err", range_err, 0);
    chk("async_rom_address", rom_address, 0);
    chk("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    cyc();
    reset_n = 1'b1; instr_ready = 1'b1; run = 1'b1;
    repeat (65540) @(posedge clock);
    @(negedge clock);
    chk("count_saturated", instr_count, 16'hFFFF);
    chk("range_err_after_reset", range_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
